flexbex_irq_ctrl: RTL and testbench
===================================

# flexbex_irq_ctrl

Parametrised interrupt front-end for the flexbex/ibex core. It latches up to N_IRQ interrupt lines, each configurable as level or edge, and applies a software mask. It picks the winner by fixed priority and presents a single request/ID pair to the core controller's `irq_req_ctrl_i`/`irq_id_ctrl_i`. The ID is frozen until the controller acknowledges.

## Interface
- `N_IRQ`, default 16: number of interrupt lines, 1..32.
- `ID_W`, default 5: ID width; must satisfy 2^ID_W >= N_IRQ.
- `EDGE_MASK`, default 0: bit k=1 makes line k rising-edge triggered; bit k=0 makes it level triggered.
- `clk` in 1: core clock; all state is on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `irq_i` in N_IRQ: raw interrupt lines.
- `mask_we_i` in 1: load `mask_wdata_i` into the enable mask.
- `mask_wdata_i` in N_IRQ: new mask value; 1 = enabled.
- `pend_clr_i` in N_IRQ: software clear of edge-pending bits.
- `irq_ack_i` in 1: controller accepted the interrupt (from `irq_ack_o`).
- `irq_ack_id_i` in ID_W: ID being acknowledged.
- `irq_req_ctrl_o` out 1: request to the controller.
- `irq_id_ctrl_o` out ID_W: ID of the requesting line.
- `irq_wake_o` out 1: any pending line, ignoring the mask; wakes the controller from sleep.
- `mask_o` out N_IRQ: current mask, for CSR read.
- `pending_o` out N_IRQ: current pending vector, for CSR read.

## Operation
- Pending vector:
  - Edge line k: set on `irq_q[k] & ~irq_prev[k]`. Cleared by `pend_clr_i[k]` or by an accepted ack with `irq_ack_id_i==k`. A new edge in the same cycle as a clear wins, so the bit stays set.
  - Level line k: pending follows `irq_q[k]` directly; ack and clear have no effect on it.
- Eligible vector = pending & mask. The winner is the lowest eligible index.
- FSM:
  - IDLE: if eligible is non-zero, register the winner ID and go to REQ.
  - REQ: `irq_req_ctrl_o`=1 and the ID is held stable.
    - If `irq_ack_i`, go to GAP.
    - Else if the held line is no longer eligible (mask write, software clear, level dropped), deassert and go to IDLE.
    - A higher-priority arrival does not replace the held ID.
  - GAP: request low for exactly one cycle so the controller cannot re-take the same request while it vectors; then go to IDLE.
- Ack handling:
  - An ack is honoured only in REQ with `irq_ack_id_i == irq_id_ctrl_o`.
  - An ack in any other state, or with a mismatched ID, is ignored and the FSM stays put.
- Simultaneous events:
  - Ack and mask write in the same cycle: the ack completes (go to GAP); the mask updates.
  - Ack and withdraw condition in the same cycle: the ack wins.
- `mask_we_i` takes effect on the next cycle's eligibility.
- `irq_wake_o` = |pending, combinational from registered state.
- IDs at or above N_IRQ are never produced.

## Timing
- Reset values: `irq_req_ctrl_o`=0, `irq_id_ctrl_o`=0, `irq_wake_o`=0, `mask_o`=0, `pending_o`=0. FSM=IDLE, `irq_prev`=0.
- Latency without sync: `irq_i` rises in cycle 0 → pending in cycle 1 → `irq_req_ctrl_o` in cycle 2. Add 2 cycles when synchronisers are compiled in.
- Ack in cycle n → request low in n+1 (GAP). The earliest re-request is in n+3.
- Reset mid-request: the request drops asynchronously and all pending bits clear. Edges present during reset are lost.

## Configuration
- `FLEXBEX_IRQ_SYNC_EN`:
  - Defined: each `irq_i` bit passes through a 2-flop synchroniser (reset 0) before `irq_q`. Latency is +2 cycles.
  - Undefined: `irq_q = irq_i` and the inputs are assumed synchronous to `clk`.

## Structure
- Shared package `flexbex_irq_pkg`:
  - FSM state enum (IDLE/REQ/GAP, 2 bits).
  - `IRQ_ID_W_MAX = 5`.
  - Function `prio_enc` (lowest-set-bit index).
- One sub-module: `flexbex_irq_sync`, a parametrised-width 2-flop synchroniser, instantiated only under `FLEXBEX_IRQ_SYNC_EN`.

## Test plan
- N_IRQ=16, EDGE_MASK=0, mask=16'hFFFF, raise `irq_i[5]` → `irq_req_ctrl_o`=1 with ID=5 two cycles later. Ack ID 5 with the line held high → GAP for one cycle, then re-request ID 5.
- Lines 9 and 3 raised in the same cycle → ID=3. Raise line 1 while in REQ → ID stays 3 until acked, then ID=1 after GAP.
- Edge line 7 (EDGE_MASK bit 7 set): 1-cycle pulse → `pending_o[7]`=1 → request ID 7. Ack → `pending_o[7]`=0 and no re-request.
- In REQ for ID 4, write mask bit 4=0 → request drops the next cycle; `irq_wake_o` remains 1.
- Ack with `irq_ack_id_i`=2 while holding ID 4 → ignored, request stays high. A second edge on line 7 in the same cycle as `pend_clr_i[7]` → pending stays 1.
- Assert `rst` during REQ → all outputs 0 immediately. After release with lines low, no request appears. With `FLEXBEX_IRQ_SYNC_EN`, first-request latency measures 4 cycles.

Source files
------------

// File: rtl/flexbex_irq_pkg.sv
// Shared types and helpers for the flexbex interrupt front-end.
package flexbex_irq_pkg;

  localparam int IRQ_ID_W_MAX = 5;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_GAP  = 2'd2
  } irq_state_e;

  // Lowest set bit wins; returns 0 for an empty vector.
  function automatic logic [IRQ_ID_W_MAX-1:0] prio_enc(input logic [31:0] vec);
    logic [IRQ_ID_W_MAX-1:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = IRQ_ID_W_MAX'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/flexbex_irq_sync.sv
// Parametrised-width two-flop synchroniser, cleared to 0 on reset.
module flexbex_irq_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_reg;
  logic [W-1:0] sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d_i;
      sync_reg <= meta_reg;
    end
  end

  assign q_o = sync_reg;

endmodule

// File: rtl/flexbex_irq_ctrl.sv
// Interrupt front-end: level/edge pending, mask, fixed priority, held request/ID until ack.
// Optional input synchronisers are compiled in with FLEXBEX_IRQ_SYNC_EN.
module flexbex_irq_ctrl
  import flexbex_irq_pkg::*;
#(
  parameter int          N_IRQ     = 16,
  parameter int          ID_W      = 5,
  parameter logic [31:0] EDGE_MASK = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic             mask_we_i,
  input  logic [N_IRQ-1:0] mask_wdata_i,
  input  logic [N_IRQ-1:0] pend_clr_i,
  input  logic             irq_ack_i,
  input  logic [ID_W-1:0]  irq_ack_id_i,
  output logic             irq_req_ctrl_o,
  output logic [ID_W-1:0]  irq_id_ctrl_o,
  output logic             irq_wake_o,
  output logic [N_IRQ-1:0] mask_o,
  output logic [N_IRQ-1:0] pending_o
);

  localparam logic [1:0] S_IDLE = 2'(IRQ_IDLE);
  localparam logic [1:0] S_REQ  = 2'(IRQ_REQ);
  localparam logic [1:0] S_GAP  = 2'(IRQ_GAP);

  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] irq_prev_reg;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] mask_reg, mask_next;
  logic [N_IRQ-1:0] pend_reg, pend_next;
  logic [N_IRQ-1:0] elig, elig_next, held_sel;
  logic [31:0]      elig_ext;
  logic [1:0]       state_reg, state_next;
  logic [ID_W-1:0]  id_reg, id_next;
  logic             ack_ok;
  logic             held_elig_next;

`ifdef FLEXBEX_IRQ_SYNC_EN
  flexbex_irq_sync #(.W(N_IRQ)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (irq_i),
    .q_o (irq_q)
  );
`else
  assign irq_q = irq_i;
`endif

  assign rise      = irq_q & ~irq_prev_reg;
  assign ack_ok    = (state_reg == S_REQ) && irq_ack_i && (irq_ack_id_i == id_reg);
  assign mask_next = mask_we_i ? mask_wdata_i : mask_reg;

  // A fresh edge beats a same-cycle clear; level lines simply track the input.
  for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_pend
    if (EDGE_MASK[gi]) begin : g_edge
      assign pend_next[gi] = rise[gi] |
                             (pend_reg[gi] & ~pend_clr_i[gi] & ~(ack_ok && (id_reg == ID_W'(gi))));
    end else begin : g_level
      assign pend_next[gi] = irq_q[gi];
    end
  end

  assign elig      = pend_reg & mask_reg;
  assign elig_ext  = 32'(elig);
  assign elig_next = pend_next & mask_next;
  assign held_sel  = N_IRQ'(1) << id_reg;
  // Withdraw looks ahead so the request never shows with an ineligible ID.
  assign held_elig_next = |(elig_next & held_sel);

  always_comb begin
    state_next = state_reg;
    id_next    = id_reg;
    case (state_reg)
      S_IDLE: begin
        if (|elig) begin
          id_next    = ID_W'(prio_enc(elig_ext));
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (ack_ok)               state_next = S_GAP;
        else if (!held_elig_next) state_next = S_IDLE;
      end
      S_GAP:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_prev_reg <= '0;
      mask_reg     <= '0;
      pend_reg     <= '0;
      state_reg    <= S_IDLE;
      id_reg       <= '0;
    end else begin
      irq_prev_reg <= irq_q;
      mask_reg     <= mask_next;
      pend_reg     <= pend_next;
      state_reg    <= state_next;
      id_reg       <= id_next;
    end
  end

  assign irq_req_ctrl_o = (state_reg == S_REQ);
  assign irq_id_ctrl_o  = id_reg;
  assign irq_wake_o     = |pend_reg;
  assign mask_o         = mask_reg;
  assign pending_o      = pend_reg;

endmodule

// File: tb/tb_flexbex_irq_ctrl.sv
// Vector-table and scoreboard bench for flexbex_irq_ctrl (line 7 edge-triggered).
module tb_flexbex_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] irq_i, mask_wdata_i, pend_clr_i, mask_o, pending_o;
  logic        mask_we_i, irq_ack_i, irq_req_ctrl_o, irq_wake_o;
  logic [4:0]  irq_ack_id_i, irq_id_ctrl_o;

  int n_checks = 0;
  int n_errors = 0;

`ifdef FLEXBEX_IRQ_SYNC_EN
  localparam int EXP_LAT = 4;
`else
  localparam int EXP_LAT = 2;
`endif

  flexbex_irq_ctrl #(.N_IRQ(16), .ID_W(5), .EDGE_MASK(32'h0000_0080)) dut (
    .clk            (clk),
    .rst            (rst),
    .irq_i          (irq_i),
    .mask_we_i      (mask_we_i),
    .mask_wdata_i   (mask_wdata_i),
    .pend_clr_i     (pend_clr_i),
    .irq_ack_i      (irq_ack_i),
    .irq_ack_id_i   (irq_ack_id_i),
    .irq_req_ctrl_o (irq_req_ctrl_o),
    .irq_id_ctrl_o  (irq_id_ctrl_o),
    .irq_wake_o     (irq_wake_o),
    .mask_o         (mask_o),
    .pending_o      (pending_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] irq;
    logic        we;
    logic [15:0] wd;
    logic [15:0] clr;
    logic        ack;
    logic [4:0]  aid;
    logic        req;
    logic [4:0]  id;
    logic [15:0] pend;
    logic        wake;
  } vec_t;

  typedef struct {
    logic        req;
    logic [4:0]  id;
    logic [15:0] pend;
    logic        wake;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic add(input logic [15:0] irq, input logic we, input logic [15:0] wd,
                     input logic [15:0] clr, input logic ack, input logic [4:0] aid,
                     input logic req, input logic [4:0] id, input logic [15:0] pend,
                     input logic wake);
    vec_t v;
    v.irq = irq; v.we = we; v.wd = wd; v.clr = clr; v.ack = ack; v.aid = aid;
    v.req = req; v.id = id; v.pend = pend; v.wake = wake;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] irq, input logic we, input logic [15:0] wd,
                       input logic [15:0] clr, input logic ack, input logic [4:0] aid);
    irq_i = irq; mask_we_i = we; mask_wdata_i = wd;
    pend_clr_i = clr; irq_ack_i = ack; irq_ack_id_i = aid;
  endtask

  initial begin
    exp_t e;
    int   lat;
    rst = 1'b1;
    drive(16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 5'd0);

    //   irq      we  wdata     clr      ack  aid   req  id   pend     wake
    add(16'h0000, 1, 16'hFFFF, 16'h0000, 0, 5'd0, 0, 5'd0, 16'h0000, 0);
    add(16'h0020, 0, 16'h0000, 16'h0000, 0, 5'd0, 0, 5'd0, 16'h0020, 1);
    add(16'h0020, 0, 16'h0000, 16'h0000, 0, 5'd0, 1, 5'd5, 16'h0020, 1);
    add(16'h0020, 0, 16'h0000, 16'h0000, 1, 5'd5, 0, 5'd5, 16'h0020, 1);
    add(16'h0020, 0, 16'h0000, 16'h0000, 0, 5'd0, 0, 5'd5, 16'h0020, 1);
    add(16'h0020, 0, 16'h0000, 16'h0000, 0, 5'd0, 1, 5'd5, 16'h0020, 1);
    add(16'h0020, 0, 16'h0000, 16'h0000, 1, 5'd5, 0, 5'd5, 16'h0020, 1);
    add(16'h0000, 0, 16'h0000, 16'h0000, 0, 5'd0, 0, 5'd5, 16'h0000, 0);
    add(16'h0000, 0, 16'h0000, 16'h0000, 0, 5'd0, 0, 5'd5, 16'h0000, 0);
    add(16'h0208, 0, 16'h0000, 16'h0000, 0, 5'd0, 0, 5'd5, 16'h0208, 1);
    add(16'h0208, 0, 16'h0000, 16'h0000, 0, 5'd0, 1, 5'd3, 16'h0208, 1);
    add(16'h020A, 0, 16'h0000, 16'h0000, 0, 5'd0, 1, 5'd3, 16'h020A, 1);
    add(16'h020A, 0, 16'h0000, 16'h0000, 0, 5'd0, 1, 5'd3, 16'h020A, 1);
    add(16'h020A, 0, 16'h0000, 16'h0000, 1, 5'd3, 0, 5'd3, 16'h020A, 1);
    add(16'h0002, 0, 16'h0000, 16'h0000, 0, 5'd0, 0, 5'd3, 16'h0002, 1);
    add(16'h0002, 0, 16'h0000, 16'h0000, 0, 5'd0, 1, 5'd1, 16'h0002, 1);
    add(16'h0000, 0, 16'h0000, 16'h0000, 1, 5'd1, 0, 5'd1, 16'h0000, 0);
    add(16'h0000, 0, 16'h0000, 16'h0000, 0, 5'd0, 0, 5'd1, 16'h0000, 0);
    add(16'h0080, 0, 16'h0000, 16'h0000, 0, 5'd0, 0, 5'd1, 16'h0080, 1);
    add(16'h0000, 0, 16'h0000, 16'h0000, 0, 5'd0, 1, 5'd7, 16'h0080, 1);
    add(16'h0000, 0, 16'h0000, 16'h0000, 0, 5'd0, 1, 5'd7, 16'h0080, 1);
    add(16'h0000, 0, 16'h0000, 16'h0000, 1, 5'd7, 0, 5'd7, 16'h0000, 0);
    add(16'h0000, 0, 16'h0000, 16'h0000, 1, 5'd7, 0, 5'd7, 16'h0000, 0);
    add(16'h0000, 0, 16'h0000, 16'h0000, 0, 5'd0, 0, 5'd7, 16'h0000, 0);
    add(16'h0010, 0, 16'h0000, 16'h0000, 0, 5'd0, 0, 5'd7, 16'h0010, 1);
    add(16'h0010, 0, 16'h0000, 16'h0000, 0, 5'd0, 1, 5'd4, 16'h0010, 1);
    add(16'h0010, 0, 16'h0000, 16'h0000, 1, 5'd2, 1, 5'd4, 16'h0010, 1);
    add(16'h0010, 1, 16'hFFEF, 16'h0000, 0, 5'd0, 0, 5'd4, 16'h0010, 1);
    add(16'h0010, 0, 16'h0000, 16'h0000, 0, 5'd0, 0, 5'd4, 16'h0010, 1);
    add(16'h0090, 0, 16'h0000, 16'h0000, 0, 5'd0, 0, 5'd4, 16'h0090, 1);
    add(16'h0010, 0, 16'h0000, 16'h0000, 0, 5'd0, 1, 5'd7, 16'h0090, 1);
    add(16'h0090, 0, 16'h0000, 16'h0080, 0, 5'd0, 1, 5'd7, 16'h0090, 1);
    add(16'h0010, 0, 16'h0000, 16'h0080, 0, 5'd0, 0, 5'd7, 16'h0010, 1);
    add(16'h0000, 0, 16'h0000, 16'h0000, 0, 5'd0, 0, 5'd7, 16'h0000, 0);

    repeat (2) @(negedge clk);
    chk("rst.req",  32'(irq_req_ctrl_o), 32'd0);
    chk("rst.id",   32'(irq_id_ctrl_o),  32'd0);
    chk("rst.wake", 32'(irq_wake_o),     32'd0);
    chk("rst.mask", 32'(mask_o),         32'd0);
    chk("rst.pend", 32'(pending_o),      32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].irq, vecs[i].we, vecs[i].wd, vecs[i].clr, vecs[i].ack, vecs[i].aid);
      sb.push_back('{req: vecs[i].req, id: vecs[i].id, pend: vecs[i].pend, wake: vecs[i].wake});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d.req", i),  32'(irq_req_ctrl_o), 32'(e.req));
      chk($sformatf("v%0d.id", i),   32'(irq_id_ctrl_o),  32'(e.id));
      chk($sformatf("v%0d.pend", i), 32'(pending_o),      32'(e.pend));
      chk($sformatf("v%0d.wake", i), 32'(irq_wake_o),     32'(e.wake));
      $display("vec %0d irq=%04h ack=%0d/%0d -> req=%0d id=%0d pend=%04h", i,
               vecs[i].irq, vecs[i].ack, vecs[i].aid, irq_req_ctrl_o, irq_id_ctrl_o, pending_o);
    end
    chk("mask.after", 32'(mask_o), 32'h0000_FFEF);

    // Reset in the middle of a request drops everything asynchronously.
    @(negedge clk);
    drive(16'h0020, 1'b0, 16'h0, 16'h0, 1'b0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst.req", 32'(irq_req_ctrl_o), 32'd1);
    chk("pre_rst.id",  32'(irq_id_ctrl_o),  32'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst.req",  32'(irq_req_ctrl_o), 32'd0);
    chk("mid_rst.id",   32'(irq_id_ctrl_o),  32'd0);
    chk("mid_rst.pend", 32'(pending_o),      32'd0);
    chk("mid_rst.mask", 32'(mask_o),         32'd0);
    chk("mid_rst.wake", 32'(irq_wake_o),     32'd0);
    irq_i = 16'h0;
    @(negedge clk);
    rst = 1'b0;
    drive(16'h0, 1'b1, 16'hFFFF, 16'h0, 1'b0, 5'd0);
    @(negedge clk);
    mask_we_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst.req",  32'(irq_req_ctrl_o), 32'd0);
    chk("post_rst.wake", 32'(irq_wake_o),     32'd0);
    $display("reset sequence -> req=%0d pend=%04h", irq_req_ctrl_o, pending_o);

    // First-request latency, bounded.
    @(negedge clk);
    irq_i = 16'h0020;
    lat = 0;
    while (!irq_req_ctrl_o && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency",    32'(lat),           32'(EXP_LAT));
    chk("latency.id", 32'(irq_id_ctrl_o), 32'd5);
    $display("latency measured %0d cycles", lat);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
